latch_write_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit D-latch bank among N requesters. It accepts a write request, captures the winner's data, and sequences the latch through a setup, open and close cycle. The latch never sees data change while its enable is high. It sits between requester logic and the shared `d_latch` bank: it drives the bank's `d` and enable inputs and returns a completion pulse to the requester.

---
 rtl/latch_write_arbiter.sv | 124 ++++++++++++
 tb/tb_latch_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_arbiter.sv
// Round-robin owner of a shared D-latch bank: captures the winner's data, then
// walks the latch enable through setup / open / close so d never moves under an open latch.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; arbitrate when any request is pending
// S_SETUP | latch_d stable, latch_en low, pulse counter loaded
// S_OPEN  | latch_en high for PULSE cycles
// S_CLOSE | latch_en low, latch_d held, ack to owner, pointer advances
module latch_write_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int PULSE = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N-1:0]       i_req,
   input  logic [N*WIDTH-1:0] i_wdata,
   output logic [N-1:0]       o_grant,
   output logic [N-1:0]       o_ack,
   output logic               o_latch_en,
   output logic [WIDTH-1:0]   o_latch_d,
   output logic               o_busy
);

   localparam int PTR_W = $clog2(N);
   localparam int CNT_W = (PULSE > 1) ? $clog2(PULSE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_CLOSE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_owner;
   logic [PTR_W-1:0]   w_owner_nxt;
   logic [PTR_W-1:0]   w_hi;
   logic [PTR_W-1:0]   w_any;
   logic               w_hi_ok;
   logic [PTR_W-1:0]   w_win;
   logic               w_found;
   logic [WIDTH-1:0]   w_win_data;
   logic [N-1:0]       w_owner_oh;
   logic [CNT_W-1:0]   r_cnt;
   logic [N-1:0]       r_grant;
   logic [N-1:0]       r_ack;
   logic               r_latch_en;
   logic [WIDTH-1:0]   r_latch_d;
   logic               r_busy;

   // Lowest set request at or above ptr wins; otherwise the lowest set request overall (wrap).
   always_comb begin
      w_found = |i_req;
      w_hi    = '0;
      w_any   = '0;
      w_hi_ok = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (i_req[i]) begin
            w_any = PTR_W'(i);
            if (PTR_W'(i) >= r_ptr) begin
               w_hi    = PTR_W'(i);
               w_hi_ok = 1'b1;
            end
         end
      end
      w_win = w_hi_ok ? w_hi : w_any;
      w_win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (PTR_W'(i) == w_win) w_win_data = i_wdata[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_nxt = S_SETUP;
         S_SETUP: w_state_nxt = S_OPEN;
         S_OPEN:  if (r_cnt == '0) w_state_nxt = S_CLOSE;
         S_CLOSE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_owner_nxt = (r_state == S_IDLE && w_found) ? w_win : r_owner;
      w_owner_oh  = '0;
      w_owner_oh[w_owner_nxt] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Outputs are registered from the next-state decode so they line up with the state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr      <= '0;
         r_owner    <= '0;
         r_cnt      <= '0;
         r_grant    <= '0;
         r_ack      <= '0;
         r_latch_en <= 1'b0;
         r_latch_d  <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_owner <= w_owner_nxt;
         if (r_state == S_IDLE && w_found) r_latch_d <= w_win_data;
         if (r_state == S_SETUP)
            r_cnt <= CNT_W'(PULSE-1);
         else if (r_state == S_OPEN && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
         if (r_state == S_CLOSE)
            r_ptr <= (r_owner == PTR_W'(N-1)) ? '0 : r_owner + 1'b1;
         r_grant    <= (w_state_nxt != S_IDLE)  ? w_owner_oh : '0;
         r_ack      <= (w_state_nxt == S_CLOSE) ? w_owner_oh : '0;
         r_latch_en <= (w_state_nxt == S_OPEN);
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

   assign o_grant    = r_grant;
   assign o_ack      = r_ack;
   assign o_latch_en = r_latch_en;
   assign o_latch_d  = r_latch_d;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: PULSE=2 and PULSE=1 instances, table-driven writes,
// scoreboard on ack, and hand sequences for round-robin, withdrawal, reset and wrap.
module tb_latch_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req0, req1;
   logic [31:0] wdata0, wdata1;
   logic [3:0]  grant0, grant1, ack0, ack1;
   logic        en0, en1, busy0, busy1;
   logic [7:0]  d0, d1, q0, q1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {logic [3:0] ack; logic [7:0] d;} sb_t;
   sb_t sb0[$];
   sb_t sb1[$];

   typedef struct {
      logic [3:0] grant;
      logic [3:0] ack;
      logic       en;
      logic [7:0] d;
      logic       busy;
      logic [7:0] q;
   } obs_t;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] wdata;
      logic [3:0]  eg;
      logic [7:0]  ed;
   } vec_t;
   vec_t tbl[7];

   latch_write_arbiter #(.N(4), .WIDTH(8), .PULSE(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_wdata(wdata0),
      .o_grant(grant0), .o_ack(ack0), .o_latch_en(en0), .o_latch_d(d0), .o_busy(busy0));

   latch_write_arbiter #(.N(4), .WIDTH(8), .PULSE(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_wdata(wdata1),
      .o_grant(grant1), .o_ack(ack1), .o_latch_en(en1), .o_latch_d(d1), .o_busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the shared D-latch bank.
   always @(en0 or d0) if (en0) q0 = d0;
   always @(en1 or d1) if (en1) q1 = d1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic obs_t get(input int inst);
      obs_t o;
      if (inst == 0) begin
         o.grant = grant0; o.ack = ack0; o.en = en0; o.d = d0; o.busy = busy0; o.q = q0;
      end else begin
         o.grant = grant1; o.ack = ack1; o.en = en1; o.d = d1; o.busy = busy1; o.q = q1;
      end
      return o;
   endfunction

   task automatic drive(input int inst, input logic [3:0] r, input logic [31:0] wd);
      if (inst == 0) begin req0 = r; wdata0 = wd; end
      else           begin req1 = r; wdata1 = wd; end
   endtask

   task automatic set_req(input int inst, input logic [3:0] r);
      if (inst == 0) req0 = r; else req1 = r;
   endtask

   task automatic scramble(input int inst);
      if (inst == 0) wdata0 = $urandom; else wdata1 = $urandom;
   endtask

   task automatic push(input int inst, input logic [3:0] a, input logic [7:0] d);
      sb_t e;
      e.ack = a;
      e.d   = d;
      if (inst == 0) sb0.push_back(e); else sb1.push_back(e);
   endtask

   // One complete write; owner's data is scrambled every cycle after capture.
   task automatic run_write(input int inst, input logic [3:0] r, input logic [31:0] wd,
                            input logic [3:0] eg, input logic [7:0] ed);
      obs_t o;
      int   p, en_cnt, ack_at;
      logic got;
      p = (inst == 0) ? 2 : 1;
      @(posedge clk); #1;
      drive(inst, r, wd);
      push(inst, eg, ed);
      @(posedge clk); #1;
      scramble(inst);
      @(negedge clk);
      o = get(inst);
      check("setup_grant", o.grant, eg);
      check("setup_en", o.en, 0);
      check("setup_d", o.d, ed);
      check("setup_busy", o.busy, 1);
      en_cnt = 0; ack_at = -1; got = 1'b0;
      for (int c = 0; c < 12 && !got; c++) begin
         @(posedge clk); #1;
         scramble(inst);
         @(negedge clk);
         o = get(inst);
         if (o.en) en_cnt++;
         if (o.ack != 0) begin
            got = 1'b1;
            ack_at = c;
            check("close_en", o.en, 0);
            check("close_grant", o.grant, eg);
            check("close_d", o.d, ed);
         end
      end
      check("ack_seen", got, 1);
      check("ack_latency", ack_at, p);
      check("en_cycles", en_cnt, p);
      @(posedge clk); #1;
      set_req(inst, 4'b0000);
      @(negedge clk);
      o = get(inst);
      check("idle_busy", o.busy, 0);
      check("idle_grant", o.grant, 0);
      check("idle_d_kept", o.d, ed);
      check("latch_q", o.q, ed);
   endtask

   logic       p_en0, p_en1;
   logic [7:0] p_d0, p_d1;

   always @(negedge clk) begin
      sb_t e;
      if (!rst_n) begin
         p_en0 <= 1'b0; p_d0 <= d0;
      end else begin
         if (ack0 != 0) begin
            if (sb0.size() == 0) check("sb0_unexpected_ack", ack0, 0);
            else begin
               e = sb0.pop_front();
               check("sb0_ack", ack0, e.ack);
               check("sb0_data", d0, e.d);
            end
         end
         check("inv0_grant_onehot", $onehot0(grant0), 1);
         check("inv0_ack_onehot", $onehot0(ack0), 1);
         if (en0 || p_en0) check("inv0_d_stable", d0, p_d0);
         p_en0 <= en0; p_d0 <= d0;
      end
   end

   always @(negedge clk) begin
      sb_t e;
      if (!rst_n) begin
         p_en1 <= 1'b0; p_d1 <= d1;
      end else begin
         if (ack1 != 0) begin
            if (sb1.size() == 0) check("sb1_unexpected_ack", ack1, 0);
            else begin
               e = sb1.pop_front();
               check("sb1_ack", ack1, e.ack);
               check("sb1_data", d1, e.d);
            end
         end
         check("inv1_grant_onehot", $onehot0(grant1), 1);
         check("inv1_ack_onehot", $onehot0(ack1), 1);
         if (en1 || p_en1) check("inv1_d_stable", d1, p_d1);
         p_en1 <= en1; p_d1 <= d1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rr_exp[5];
      logic [3:0] wrap_exp[2];
      int   n_ack, last, en_cnt;
      logic found;

      tbl[0] = '{4'b0010, 32'h1122A533, 4'b0010, 8'hA5};
      tbl[1] = '{4'b0001, 32'h40414243, 4'b0001, 8'h43};
      tbl[2] = '{4'b1001, 32'h5A5B5C5D, 4'b1000, 8'h5A};
      tbl[3] = '{4'b0110, 32'h60616263, 4'b0010, 8'h62};
      tbl[4] = '{4'b0011, 32'h70717273, 4'b0001, 8'h73};
      tbl[5] = '{4'b0100, 32'h80818283, 4'b0100, 8'h81};
      tbl[6] = '{4'b1111, 32'h90919293, 4'b1000, 8'h90};
      rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      wrap_exp = '{4'b1000, 4'b0001};

      rst_n = 1'b0;
      req0 = '0; req1 = '0; wdata0 = '0; wdata1 = '0;
      #1;
      check("rst_grant", grant0, 0);
      check("rst_ack", ack0, 0);
      check("rst_en", en0, 0);
      check("rst_d", d0, 0);
      check("rst_busy", busy0, 0);
      check("rst1_en", en1, 0);
      check("rst1_busy", busy1, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 7; i++)
         run_write(0, tbl[i].req, tbl[i].wdata, tbl[i].eg, tbl[i].ed);

      // Round-robin with all four requesting; pointer starts at 0 here.
      @(posedge clk); #1;
      drive(0, 4'b1111, 32'hD3D2D1D0);
      push(0, 4'b0001, 8'hD0); push(0, 4'b0010, 8'hD1); push(0, 4'b0100, 8'hD2);
      push(0, 4'b1000, 8'hD3); push(0, 4'b0001, 8'hD0);
      n_ack = 0; last = 0;
      for (int c = 0; c < 40 && n_ack < 5; c++) begin
         @(negedge clk);
         if (ack0 != 0) begin
            if (n_ack > 0) check("rr_interval", c - last, 5);
            check("rr_grant", grant0, rr_exp[n_ack]);
            last = c;
            n_ack++;
         end
      end
      check("rr_acks", n_ack, 5);
      @(posedge clk); #1;
      req0 = 4'b0000;
      @(negedge clk);
      check("rr_idle_busy", busy0, 0);

      // One-cycle request still completes; pointer is 1, so requester 0 wins by wrap.
      @(posedge clk); #1;
      drive(0, 4'b0001, 32'h000000EE);
      push(0, 4'b0001, 8'hEE);
      @(posedge clk); #1;
      req0 = 4'b0000;
      n_ack = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (ack0 != 0) n_ack++;
      end
      check("wd_acks", n_ack, 1);
      check("wd_busy", busy0, 0);
      check("wd_grant", grant0, 0);

      // Reset in the middle of OPEN.
      @(posedge clk); #1;
      drive(0, 4'b1000, 32'hC7000000);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (en0) found = 1'b1;
      end
      check("rstmid_open_reached", found, 1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmid_en", en0, 0);
      check("rstmid_grant", grant0, 0);
      check("rstmid_ack", ack0, 0);
      check("rstmid_busy", busy0, 0);
      check("rstmid_d", d0, 0);
      req0 = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      run_write(0, 4'b1001, 32'h55000066, 4'b0001, 8'h66);
      run_write(0, 4'b1000, 32'h77000000, 4'b1000, 8'h77);

      // PULSE=1 instance: grant 2, then 3 and 0 pending -> 3 then 0.
      run_write(1, 4'b0100, 32'h00AB0000, 4'b0100, 8'hAB);
      @(posedge clk); #1;
      drive(1, 4'b1001, 32'h3C0000C0);
      push(1, 4'b1000, 8'h3C); push(1, 4'b0001, 8'hC0);
      n_ack = 0; en_cnt = 0;
      for (int c = 0; c < 20 && n_ack < 2; c++) begin
         @(negedge clk);
         if (en1) en_cnt++;
         if (ack1 != 0) begin
            check("wrap_grant", grant1, wrap_exp[n_ack]);
            check("wrap_en_cycles", en_cnt, 1);
            en_cnt = 0;
            n_ack++;
         end
      end
      check("wrap_acks", n_ack, 2);
      @(posedge clk); #1;
      req1 = 4'b0000;
      repeat (3) @(negedge clk);
      check("wrap_idle_busy", busy1, 0);

      check("sb0_drained", sb0.size(), 0);
      check("sb1_drained", sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
